// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter: round-robin green-phase scheduler for four approaches
// Optional emergency preemption (preempt/preempt_id ports) enabled by EMERGENCY_PREEMPT_EN.
module intersection_phase_arbiter #(
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 12,
    parameter int unsigned YEL_TIME  = 3,
    parameter int unsigned RED_CLR   = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt,
    input  logic [1:0] preempt_id,
`endif
    output logic [7:0] lights,
    output logic [3:0] grant,
    output logic       busy,
    output logic       phase_done
);
    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
    localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
    localparam logic [7:0] MAX_G = 8'(MAX_GREEN);
    localparam logic [7:0] YEL_T = 8'(YEL_TIME);
    localparam logic [7:0] RED_T = 8'(RED_CLR);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d, cur_q, cur_d, win, pre_id;
    logic [7:0] g_q, g_d, t_q, t_d, lights_d;
    logic [3:0] grant_d;
    logic       pre_q, pre_d, pre_go, pre_hold, pre_idle, other, exit_g;

`ifdef EMERGENCY_PREEMPT_EN
    assign pre_idle = preempt;
    assign pre_id   = preempt_id;
    assign pre_go   = preempt && preempt_id != cur_q;
    assign pre_hold = preempt && preempt_id == cur_q;
`else
    assign pre_idle = 1'b0;
    assign pre_id   = 2'd0;
    assign pre_go   = 1'b0;
    assign pre_hold = 1'b0;
`endif

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        win = ptr_q;
        for (int i = 3; i >= 0; i--)
            if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end

    assign other  = |(req & ~(4'b1 << cur_q));
    assign exit_g = pre_go || (!pre_hold && g_q >= MIN_G && (!req[cur_q] || (g_q >= MAX_G && other)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        g_d     = g_q;
        t_d     = t_q;
        pre_d   = pre_q;
        unique case (state_q)
            IDLE: begin
                if (pre_idle || req != 4'b0) begin
                    state_d = GREEN;
                    cur_d   = pre_idle ? pre_id : win;
                    pre_d   = pre_idle;
                    g_d     = 8'd1;
                end
            end
            GREEN: begin
                if (exit_g) begin
                    state_d = YELLOW;
                    ptr_d   = pre_q ? ptr_q : cur_q + 2'd1;
                    t_d     = 8'd1;
                end else begin
                    g_d = (g_q >= MAX_G) ? g_q : g_q + 8'd1;
                end
            end
            YELLOW: begin
                state_d = (t_q >= YEL_T) ? ALLRED : YELLOW;
                t_d     = (t_q >= YEL_T) ? 8'd1 : t_q + 8'd1;
            end
            ALLRED: begin
                state_d = (t_q >= RED_T) ? IDLE : ALLRED;
                t_d     = (t_q >= RED_T) ? 8'd0 : t_q + 8'd1;
            end
        endcase
        lights_d = (state_d == GREEN)  ? 8'd2 << {cur_d, 1'b0} :
                   (state_d == YELLOW) ? 8'd1 << {cur_d, 1'b0} : 8'h00;
        grant_d  = (state_d == GREEN || state_d == YELLOW) ? 4'b1 << cur_d : 4'b0;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            cur_q      <= 2'd0;
            g_q        <= 8'd0;
            t_q        <= 8'd0;
            pre_q      <= 1'b0;
            lights     <= 8'h00;
            grant      <= 4'b0;
            busy       <= 1'b0;
            phase_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            g_q        <= g_d;
            t_q        <= t_d;
            pre_q      <= pre_d;
            lights     <= lights_d;
            grant      <= grant_d;
            busy       <= state_d != IDLE;
            phase_done <= state_q == ALLRED && state_d == IDLE;
        end
    end
endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb_intersection_phase_arbiter: directed stimulus with a queued scoreboard checked by a monitor
module tb_intersection_phase_arbiter;
    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] req   = 4'b0;
    logic [7:0] lights;
    logic [3:0] grant;
    logic       busy, phase_done;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt    = 1'b0;
    logic [1:0] preempt_id = 2'd0;
`endif

    intersection_phase_arbiter dut (
        .clock(clock), .clear(clear), .req(req),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt(preempt), .preempt_id(preempt_id),
`endif
        .lights(lights), .grant(grant), .busy(busy), .phase_done(phase_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [7:0] l; logic [3:0] g; logic b; logic pd;} exp_t;
    exp_t  exp_q[$];
    string nm_q[$];
    exp_t  me;
    string mn;
    int    total = 0, bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (lights,grant,busy,phase_done)", nm, act, want);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            mn = nm_q.pop_front();
            chk(mn, 16'({lights, grant, busy, phase_done}), 16'(me));
        end
    end

    function automatic logic [7:0] fld(input int ap, input logic [1:0] v);
        return 8'(v) << (2 * ap);
    endfunction

    function automatic logic [3:0] gnt(input int ap);
        return 4'b1 << ap;
    endfunction

    task automatic cyc(input logic [3:0] r, input logic [7:0] l, input logic [3:0] g,
                       input logic b, input logic pd, input string nm);
        @(negedge clock);
        req = r;
        exp_q.push_back({l, g, b, pd});
        nm_q.push_back(nm);
    endtask

    task automatic green(input logic [3:0] r, input int ap, input int n, input string nm);
        repeat (n) cyc(r, fld(ap, 2'd2), gnt(ap), 1'b1, 1'b0, nm);
    endtask

    task automatic tail(input logic [3:0] r, input int ap);
        repeat (3) cyc(r, fld(ap, 2'd1), gnt(ap), 1'b1, 1'b0, "yellow");
        repeat (2) cyc(r, 8'h00, 4'b0, 1'b1, 1'b0, "allred");
        cyc(r, 8'h00, 4'b0, 1'b0, 1'b1, "idle_done");
    endtask

    task automatic phase(input logic [3:0] r, input int ap, input int n);
        green(r, ap, n, "green_len");
        tail(r, ap);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b1;
        req   = 4'b0;
        #1 chk("reset_async", 16'({lights, grant, busy, phase_done}), 16'h0);
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        #1 clear = 1'b1;
        #1 chk("reset_initial", 16'({lights, grant, busy, phase_done}), 16'h0);
        @(negedge clock);
        clear = 1'b0;
        repeat (50) cyc(4'b0, 8'h00, 4'b0, 1'b0, 1'b0, "idle_quiet");
        // One-cycle request still earns a full minimum green.
        green(4'b0001, 0, 1, "pulse_green");
        green(4'b0000, 0, 3, "pulse_green");
        tail(4'b0000, 0);
        cyc(4'b0, 8'h00, 4'b0, 1'b0, 1'b0, "idle_after");
        do_reset();
        green(4'b0001, 0, 1, "pre_clr_green");
        green(4'b0000, 0, 3, "pre_clr_green");
        cyc(4'b0, fld(0, 2'd1), 4'b0001, 1'b1, 1'b0, "pre_clr_yellow");
        @(posedge clock);
        #3 clear = 1'b1;
        #1 chk("clear_mid_yellow", 16'({lights, grant, busy, phase_done}), 16'h0);
        @(negedge clock);
        clear = 1'b0;
        do_reset();
        phase(4'b0101, 0, 12);
        phase(4'b0101, 2, 12);
        phase(4'b0101, 0, 12);
        phase(4'b0101, 2, 12);
        do_reset();
        for (int a = 0; a < 4; a++) phase(4'b1111, a, 12);
        green(4'b1111, 0, 12, "rr_wrap");
        do_reset();
        green(4'b0010, 1, 200, "rest_green");
        tail(4'b1010, 1);
        green(4'b1010, 3, 5, "after_rest");
`ifdef EMERGENCY_PREEMPT_EN
        do_reset();
        green(4'b0001, 0, 2, "pre_g");
        @(posedge clock);
        #2;
        preempt    = 1'b1;
        preempt_id = 2'd2;
        tail(4'b1011, 0);
        green(4'b1011, 2, 30, "pre_hold");
        @(posedge clock);
        #2 preempt = 1'b0;
        tail(4'b1011, 2);
        green(4'b1011, 1, 3, "pre_ptr_kept");
`endif
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intersection_phase_arbiter.md
Name: intersection_phase_arbiter

Overview:
- Four-approach signal scheduler. Shares one green phase among four approach requesters, round-robin.
- Each approach has a car sensor.
- Enforces minimum and maximum green time, a yellow interval and an all-red clearance between phases.
- Guarantees that at most one approach shows non-RED in any cycle.
- Light encoding: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.

Parameters:
- MIN_GREEN, 4, minimum green cycles once granted (>=1)
- MAX_GREEN, 12, green cycles after which a contested green is terminated (>=MIN_GREEN, <=255)
- YEL_TIME, 3, yellow cycles (>=1)
- RED_CLR, 2, all-red clearance cycles after yellow (>=1)

Ports:
- clock  in  1  single clock; all state changes on posedge
- clear  in  1  asynchronous, active-high reset
- req  in  4  car-present sensor per approach; level, sampled each posedge
- lights  out  8  lights[2i+1:2i] = signal for approach i; registered
- grant  out  4  one-hot, approach currently GREEN or YELLOW; 0 otherwise; registered
- busy  out  1  high in GREEN, YELLOW and ALLRED states
- phase_done  out  1  one-cycle pulse on the first IDLE cycle after ALLRED

Behaviour:
- Reset, while clear=1, asynchronous:
  - state=IDLE, lights=8'h00, grant=0, busy=0, phase_done=0.
  - ptr=0, cur=0, all timers=0.
- States: IDLE, GREEN, YELLOW, ALLRED.
- IDLE:
  - All lights RED.
  - If req!=0, winner = first set bit of req scanning ptr, ptr+1, ... mod 4.
  - cur=winner, green counter g=1, next state GREEN.
  - If req=0, remain in IDLE indefinitely.
- GREEN:
  - lights[cur]=GREEN, grant[cur]=1.
  - other = |(req & ~(1<<cur)).
  - exit = (g>=MIN_GREEN) && (!req[cur] || (g>=MAX_GREEN && other)).
  - On exit: next state YELLOW, ptr=(cur+1) mod 4, yellow timer=1.
  - Otherwise g increments, saturating at MAX_GREEN.
  - Displayed green length = g at exit.
  - If req[cur] is held and other=0, green rests indefinitely. The first cycle other=1 with g>=MAX_GREEN causes yellow on the next cycle.
- YELLOW:
  - lights[cur]=YELLOW, grant[cur]=1.
  - Lasts exactly YEL_TIME cycles, then ALLRED.
  - req changes are ignored.
- ALLRED:
  - All RED, grant=0.
  - Lasts exactly RED_CLR cycles, then IDLE with phase_done=1 for that one cycle.
- Timing:
  - Gap between one green ending and the next green starting is exactly YEL_TIME+RED_CLR+1 cycles, because IDLE takes one cycle minimum.
  - Latency from reset-state IDLE with req asserted to GREEN displayed is 1 cycle.
- Counters are 8-bit unsigned. Wrap-around is impossible because g saturates.
- ptr wraps 3 to 0.
- A req pulse shorter than one cycle is not guaranteed to be seen. A req seen for one cycle in IDLE yields a full MIN_GREEN green.
- clear asserted mid-phase: lights go to all RED immediately, asynchronously. No yellow is shown. After release, restart from IDLE with ptr=0.
- Invariant: at most one 2-bit field of lights is non-zero. grant equals the set of non-RED fields.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- Defined: adds ports preempt (in, 1) and preempt_id (in, 2).
  - preempt=1 in GREEN with cur!=preempt_id: YELLOW next cycle, ignoring MIN_GREEN.
  - preempt=1 in GREEN with cur==preempt_id: green held regardless of MAX_GREEN and req.
  - In YELLOW/ALLRED: sequence completes normally.
  - In IDLE with preempt=1: winner=preempt_id, bypassing round-robin and req. ptr is not modified by a preempted grant.
  - Deasserting preempt returns to normal rules, with g continuing from its saturated value.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Assert clear, req=0 for 50 cycles after release -> lights=8'h00, grant=0, busy=0 throughout. clear mid-YELLOW -> lights=8'h00 within the same cycle.
- req=4'b0001 for one cycle from IDLE -> lights=8'h02 for 4 cycles, 8'h01 for 3, 8'h00 for 2, then IDLE with phase_done pulse. Total busy = 9 cycles.
- req=4'b0101 held -> green alternates approach 0, 2, 0, 2. Each green lasts 12 cycles; 6 cycles between greens. lights toggles 8'h02 / 8'h20.
- req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001. No approach skipped or repeated.
- req=4'b0010 held for 200 cycles -> approach 1 stays GREEN (lights=8'h08). Then set req[3] -> YELLOW starts on the next cycle, then approach 3 green after 6 cycles.
- With EMERGENCY_PREEMPT_EN: approach 0 green at g=2 and preempt=1, preempt_id=2 -> YELLOW next cycle, then ALLRED, IDLE, then lights=8'h20 held while preempt=1, even with req=4'b1011.
